// File: rtl/result_tx_formatter.sv
// Formats a divider result {remainder, quotient} as ASCII hex "QQ RR" for a UART, one byte per transfer.
// Optional macro FMT_CRLF_EN appends CR LF to each sequence.
module result_tx_formatter (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] result,
  input  logic        alu_done,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        busy,
  output logic        fmt_done,
  output logic        overrun
);

  typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;

`ifdef FMT_CRLF_EN
  localparam logic [2:0] LAST_IDX = 3'd6;
`else
  localparam logic [2:0] LAST_IDX = 3'd4;
`endif

  state_t      state_q, state_d;
  logic [11:0] res_q, res_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  byte_sel;

  function automatic logic [7:0] hex(input logic [3:0] n);
    return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      res_q   <= 12'h000;
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    idx_d    = idx_q;
    tx_valid = 1'b0;
    busy     = 1'b0;
    fmt_done = 1'b0;
    overrun  = 1'b0;
    case (state_q)
      IDLE: begin
        if (alu_done) begin
          res_d   = result;
          idx_d   = 3'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        overrun  = alu_done;
        // Index only advances on an actual transfer, so backpressure holds the byte.
        if (tx_ready) begin
          if (idx_q == LAST_IDX) state_d = FIN;
          else                   idx_d   = idx_q + 3'd1;
        end
      end
      FIN: begin
        busy     = 1'b1;
        fmt_done = 1'b1;
        overrun  = alu_done;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Quotient sits in res_q[5:0], remainder in res_q[11:6].
  always_comb begin
    byte_sel = 8'h00;
    case (idx_q)
      3'd0: byte_sel = hex({2'b00, res_q[5:4]});
      3'd1: byte_sel = hex(res_q[3:0]);
      3'd2: byte_sel = 8'h20;
      3'd3: byte_sel = hex({2'b00, res_q[11:10]});
      3'd4: byte_sel = hex(res_q[9:6]);
`ifdef FMT_CRLF_EN
      3'd5: byte_sel = 8'h0D;
      3'd6: byte_sel = 8'h0A;
`endif
      default: byte_sel = 8'h00;
    endcase
  end

  assign tx_data = tx_valid ? byte_sel : 8'h00;

endmodule

// File: tb/tb_result_tx_formatter.sv
// Directed bench for result_tx_formatter: nominal strings, letter boundaries, backpressure,
// overrun, mid-sequence reset and back-to-back accepts.
module tb_result_tx_formatter;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] result;
  logic        alu_done;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        busy;
  logic        fmt_done;
  logic        overrun;

  int vecs = 0;
  int errs = 0;

`ifdef FMT_CRLF_EN
  localparam int NB = 7;
`else
  localparam int NB = 5;
`endif

  typedef logic [7:0] seq_t [7];
  seq_t e043 = '{8'h30, 8'h33, 8'h20, 8'h30, 8'h31, 8'h0D, 8'h0A};
  seq_t e03f = '{8'h33, 8'h46, 8'h20, 8'h30, 8'h30, 8'h0D, 8'h0A};
  seq_t efff = '{8'h33, 8'h46, 8'h20, 8'h33, 8'h46, 8'h0D, 8'h0A};

  result_tx_formatter dut (
    .clk      (clk),
    .rst      (rst),
    .result   (result),
    .alu_done (alu_done),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .busy     (busy),
    .fmt_done (fmt_done),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks all outputs; tx_data is only compared when a byte is expected.
  task automatic chk_out(input string tag, input logic ev, input logic [7:0] ed,
                         input logic eb, input logic ef, input logic eo);
    chk({tag, "_valid"}, 8'(tx_valid), 8'(ev));
    if (ev) chk({tag, "_data"}, tx_data, ed);
    chk({tag, "_busy"}, 8'(busy), 8'(eb));
    chk({tag, "_fmt_done"}, 8'(fmt_done), 8'(ef));
    chk({tag, "_overrun"}, 8'(overrun), 8'(eo));
  endtask

  task automatic cyc(input logic d, input logic [11:0] r, input logic rdy);
    @(negedge clk);
    alu_done = d;
    result   = r;
    tx_ready = rdy;
    #1;
  endtask

  task automatic start(input string tag, input logic [11:0] r);
    cyc(1'b1, r, 1'b1);
    chk_out({tag, "_start"}, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic stream(input string tag, input seq_t e);
    for (int i = 0; i < NB; i++) begin
      cyc(1'b0, 12'h000, 1'b1);
      chk_out($sformatf("%s_b%0d", tag, i), 1'b1, e[i], 1'b1, 1'b0, 1'b0);
    end
    cyc(1'b0, 12'h000, 1'b1);
    chk_out({tag, "_fin"}, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    int n;
    int k;
    int pat [6] = '{1, 0, 0, 1, 0, 1};

    rst = 1'b1; alu_done = 1'b0; result = 12'h000; tx_ready = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    chk("reset_data", tx_data, 8'h00);
    chk_out("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Ready without valid does nothing.
    cyc(1'b0, 12'h000, 1'b1);
    chk_out("idle_rdy", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    start("q3r1", 12'h043);
    stream("q3r1", e043);
    cyc(1'b0, 12'h000, 1'b1);
    chk_out("q3r1_idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Back-to-back: FFF accepted on the first IDLE cycle after FIN.
    start("q63", 12'h03F);
    stream("q63", e03f);
    start("max", 12'hFFF);
    stream("max", efff);
    cyc(1'b0, 12'h000, 1'b0);
    chk_out("max_idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Backpressure with a 1,0,0,1,0,1 ready pattern.
    start("bp", 12'h043);
    n = 0; k = 0;
    while (n < NB && k < 60) begin
      cyc(1'b0, 12'h000, pat[k % 6] != 0);
      chk_out($sformatf("bp_c%0d", k), 1'b1, e043[n], 1'b1, 1'b0, 1'b0);
      if (pat[k % 6] != 0) n++;
      k++;
    end
    chk("bp_count", 8'(n), 8'(NB));
    cyc(1'b0, 12'h000, 1'b0);
    chk_out("bp_fin", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 12'h000, 1'b0);
    chk_out("bp_idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Overrun during SEND and FIN leaves the original sequence intact.
    start("ovr", 12'h043);
    cyc(1'b0, 12'h000, 1'b1);
    chk_out("ovr_b0", 1'b1, e043[0], 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 12'h000, 1'b1);
    chk_out("ovr_b1", 1'b1, e043[1], 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 12'hFFF, 1'b1);
    chk_out("ovr_b2", 1'b1, e043[2], 1'b1, 1'b0, 1'b1);
    for (int i = 3; i < NB; i++) begin
      cyc(1'b0, 12'h000, 1'b1);
      chk_out($sformatf("ovr_b%0d", i), 1'b1, e043[i], 1'b1, 1'b0, 1'b0);
    end
    cyc(1'b1, 12'hFFF, 1'b1);
    chk_out("ovr_fin", 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 12'h000, 1'b1);
    chk_out("ovr_idle0", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 12'h000, 1'b1);
    chk_out("ovr_idle1", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Reset after byte index 2 has transferred.
    start("rmid", 12'h043);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 12'h000, 1'b1);
      chk_out($sformatf("rmid_b%0d", i), 1'b1, e043[i], 1'b1, 1'b0, 1'b0);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rmid_rst_data", tx_data, 8'h00);
    chk_out("rmid_rst", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 12'h000, 1'b1);
      chk_out($sformatf("rmid_quiet%0d", i), 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    end
    start("rnew", 12'h043);
    stream("rnew", e043);
    cyc(1'b0, 12'h000, 1'b1);
    chk_out("rnew_idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/result_tx_formatter.md
RESULT_TX_FORMATTER -- requirements
Module: result_tx_formatter

Interface
REQ-001 The block SHALL have one clock and one asynchronous, active-high reset; ports: clk input 1 rising-edge clock; rst input 1 async active-high reset.
REQ-002 result  input  12  {remainder[11:6], quotient[5:0]} from divider, valid only while alu_done=1.
REQ-003 alu_done  input  1  single-cycle result-valid strobe from divider.
REQ-004 tx_ready  input  1  UART transmitter can accept a byte this cycle.
REQ-005 tx_data  output  8  ASCII byte offered to UART transmitter.
REQ-006 tx_valid  output  1  tx_data valid; byte transfers on a cycle with tx_valid=1 and tx_ready=1.
REQ-007 busy  output  1  high from the cycle after capture until return to IDLE.
REQ-008 fmt_done  output  1  single-cycle pulse after the final byte transfers.
REQ-009 overrun  output  1  single-cycle pulse when alu_done arrives while not in IDLE.

Function
REQ-010 FSM states SHALL be IDLE, SEND, FIN; the FSM SHALL start in IDLE.
REQ-011 In IDLE, alu_done=1 SHALL capture result into an internal 12-bit register, clear the byte index to 0, and enter SEND on the next edge.
REQ-012 tx_valid SHALL be high in every SEND cycle, so the first byte is offered the cycle after alu_done (1-cycle latency); tx_valid SHALL be low in IDLE and FIN.
REQ-013 Byte order SHALL be: index 0 = hex(quotient[5:4]), 1 = hex(quotient[3:0]), 2 = 0x20 (space), 3 = hex(remainder[5:4]), 4 = hex(remainder[3:0]), then optional bytes per REQ-023.
REQ-014 hex(n) for 4-bit n SHALL be 0x30+n for n<=9 and 0x37+n for n>=10 (uppercase 'A'-'F'); 2-bit fields are zero-extended to 4 bits first.
REQ-015 tx_data and the byte index SHALL hold stable while tx_valid=1 and tx_ready=0 (no byte skipped or repeated under backpressure).
REQ-016 On each transfer the index SHALL increment; a transfer of the last byte SHALL move the FSM to FIN.
REQ-017 FIN SHALL last exactly one cycle with fmt_done=1, then return to IDLE; back-to-back alu_done is accepted in the first IDLE cycle after FIN.
REQ-018 alu_done in SEND or FIN SHALL be ignored for data (captured result unchanged, sequence uninterrupted) and SHALL raise overrun for that single cycle.
REQ-019 tx_ready while tx_valid=0 SHALL have no effect.
REQ-020 busy SHALL be high in SEND and FIN and low in IDLE.

Reset
REQ-021 rst=1 SHALL, asynchronously and at any point including mid-sequence, force IDLE and set tx_data=8'h00, tx_valid=0, busy=0, fmt_done=0, overrun=0, captured result=0, index=0; no partial sequence resumes after reset.
REQ-022 Operation after rst deasserts SHALL begin only on a fresh alu_done.

Configuration
REQ-023 With macro FMT_CRLF_EN defined, the sequence SHALL append index 5 = 0x0D and index 6 = 0x0A (7 bytes total, last index 6).
REQ-024 Without FMT_CRLF_EN, the sequence SHALL end at index 4 (5 bytes total), and no CR/LF logic or index states beyond 4 SHALL exist.

Verification
REQ-025 result=12'h043 (13/4: Q=3,R=1), tx_ready=1 constant -> bytes 0x30,0x33,0x20,0x30,0x31 (+0x0D,0x0A with FMT_CRLF_EN) on consecutive cycles starting 1 cycle after alu_done; fmt_done pulses once, one cycle after last byte.
REQ-026 result=12'h03F (63/1: Q=63,R=0) -> 0x33,0x46,0x20,0x30,0x30; result=12'hFFF -> 0x33,0x46,0x20,0x33,0x46 (hex letter boundary and max values).
REQ-027 result=12'h043 with tx_ready toggling 1,0,0,1,0,1,... -> tx_data held during ready=0; exactly 5 (or 7) bytes transferred, order identical to REQ-025.
REQ-028 Second alu_done with result=12'hFFF during SEND of 12'h043 -> overrun pulses 1 cycle; output remains the 12'h043 sequence; busy drops after FIN.
REQ-029 rst asserted mid-sequence after byte index 2 -> all outputs reset immediately; no further tx_valid until the next alu_done, after which a full sequence from index 0 is sent.
REQ-030 alu_done issued on the first IDLE cycle after FIN -> accepted, no overrun, new sequence starts the following cycle.
